// File: rtl/i_cache_plru_line.sv
// i_cache_plru_line: set-associative instruction cache with multi-word lines
// and tree pseudo-LRU replacement. A miss refills the whole line from the
// bridge with sequential single-word reads. Core writes are ignored.
// Optional macro ICACHE_PERF_CNT_EN adds hit/miss performance counters.
module i_cache_plru_line #(
    parameter int INDEX_WIDTH  = 7,
    parameter int OFFSET_WIDTH = 4,
    parameter int WAY_WIDTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_inst_req,
    input  logic        cpu_inst_wr,
    input  logic [1:0]  cpu_inst_size,
    input  logic [31:0] cpu_inst_addr,
    input  logic [31:0] cpu_inst_wdata,
    output logic [31:0] cpu_inst_rdata,
    output logic        cpu_inst_addr_ok,
    output logic        cpu_inst_data_ok,
    output logic        cache_inst_req,
    output logic        cache_inst_wr,
    output logic [1:0]  cache_inst_size,
    output logic [31:0] cache_inst_addr,
    output logic [31:0] cache_inst_wdata,
    input  logic [31:0] cache_inst_rdata,
    input  logic        cache_inst_addr_ok,
    input  logic        cache_inst_data_ok,
    output logic [31:0] perf_hit_cnt,
    output logic [31:0] perf_miss_cnt
);

    localparam int TAG_W  = 32 - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int SETS   = 1 << INDEX_WIDTH;
    localparam int WAYS   = 1 << WAY_WIDTH;
    localparam int WORDS  = 1 << (OFFSET_WIDTH - 2);
    localparam int BEAT_W = (OFFSET_WIDTH > 2) ? OFFSET_WIDTH - 2 : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REFILL = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    // Control state
    logic [1:0]             r_state;
    logic [BEAT_W-1:0]      r_beat;
    logic                   r_addr_sent;
    // Miss context latched at acceptance
    logic [TAG_W-1:0]       r_tag_l;
    logic [INDEX_WIDTH-1:0] r_index_l;
    logic [BEAT_W-1:0]      r_word_l;
    logic [WAY_WIDTH-1:0]   r_victim_l;
    logic [31:0]            r_buf;
    // Storage; PLRU vector has one spare top bit so node indices are WAY_WIDTH wide
    logic [WAYS-1:0]        r_valid [SETS];
    logic [WAYS-1:0]        r_plru  [SETS];
    logic [TAG_W-1:0]       r_tag   [SETS][WAYS];
    logic [31:0]            r_data  [SETS][WAYS][WORDS];

    logic [TAG_W-1:0]       w_tag;
    logic [INDEX_WIDTH-1:0] w_index;
    logic [BEAT_W-1:0]      w_word;
    logic                   w_hit;
    logic [WAY_WIDTH-1:0]   w_hit_way;
    logic [31:0]            w_hit_word;
    logic [WAY_WIDTH-1:0]   w_victim;
    logic                   w_found;
    logic                   w_beat_done;
    logic                   w_last_beat;
    logic                   w_idle_req;
    logic                   w_unused_ok;

    // Follow the tree bits from the root (0 = left, 1 = right) down to a leaf.
    function automatic logic [WAY_WIDTH-1:0] plru_victim(input logic [WAYS-1:0] bits);
        logic [WAY_WIDTH-1:0] node;
        logic [WAY_WIDTH-1:0] way;
        logic                 b;
        node = '0;
        way  = '0;
        for (int l = 0; l < WAY_WIDTH; l++) begin
            b    = bits[node];
            way  = WAY_WIDTH'({way, b});
            node = WAY_WIDTH'((32'(node) << 1) + 32'd1 + 32'(b));
        end
        return way;
    endfunction

    // Point every node on the path to `way` at the opposite subtree.
    function automatic logic [WAYS-1:0] plru_touch(input logic [WAYS-1:0] bits,
                                                   input logic [WAY_WIDTH-1:0] way);
        logic [WAYS-1:0]      nb;
        logic [WAY_WIDTH-1:0] node;
        logic [WAY_WIDTH-1:0] path;
        logic                 dir;
        nb   = bits;
        node = '0;
        path = way;
        for (int l = 0; l < WAY_WIDTH; l++) begin
            dir      = path[WAY_WIDTH-1];
            path     = path << 1;
            nb[node] = ~dir;
            node     = WAY_WIDTH'((32'(node) << 1) + 32'd1 + 32'(dir));
        end
        return nb;
    endfunction

    assign w_tag       = cpu_inst_addr[31 -: TAG_W];
    assign w_index     = cpu_inst_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign w_word      = BEAT_W'(cpu_inst_addr[31:2] & 30'(WORDS - 1));
    assign w_unused_ok = ^{cpu_inst_wr, cpu_inst_size, cpu_inst_wdata, cpu_inst_addr[1:0]};

    // Tag compare across all ways of the addressed set
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_index][w] && (r_tag[w_index][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_WIDTH'(w);
            end
        end
        w_hit_word = r_data[w_index][w_hit_way][w_word];
    end

    // Victim: lowest invalid way, otherwise the PLRU leaf
    always_comb begin
        w_victim = plru_victim(r_plru[w_index]);
        w_found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_found && !r_valid[w_index][w]) begin
                w_victim = WAY_WIDTH'(w);
                w_found  = 1'b1;
            end
        end
    end

    // A beat completes on data_ok once its address is (or is being) accepted
    assign w_beat_done = (r_state == S_REFILL) && cache_inst_data_ok &&
                         (r_addr_sent || cache_inst_addr_ok);
    assign w_last_beat = (r_beat == BEAT_W'(WORDS - 1));
    assign w_idle_req  = rst && (r_state == S_IDLE) && cpu_inst_req;

    // FSM, valid bits and PLRU tree bits
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_beat      <= '0;
            r_addr_sent <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_inst_req) begin
                        if (w_hit) begin
                            r_plru[w_index] <= plru_touch(r_plru[w_index], w_hit_way);
                        end else begin
                            r_state     <= S_REFILL;
                            r_beat      <= '0;
                            r_addr_sent <= 1'b0;
                        end
                    end
                end
                S_REFILL: begin
                    if (w_beat_done) begin
                        r_addr_sent <= 1'b0;
                        if (w_last_beat) begin
                            r_beat  <= '0;
                            r_state <= S_RESP;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end else if (cache_inst_addr_ok && !r_addr_sent) begin
                        r_addr_sent <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_valid[r_index_l][r_victim_l] <= 1'b1;
                    r_plru[r_index_l] <= plru_touch(r_plru[r_index_l], r_victim_l);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Miss context, line data, requested-word buffer and tag write
    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && cpu_inst_req && !w_hit) begin
            r_tag_l    <= w_tag;
            r_index_l  <= w_index;
            r_word_l   <= w_word;
            r_victim_l <= w_victim;
        end
        if (w_beat_done) begin
            r_data[r_index_l][r_victim_l][r_beat] <= cache_inst_rdata;
            if (r_beat == r_word_l) begin
                r_buf <= cache_inst_rdata;
            end
        end
        if (r_state == S_RESP) begin
            r_tag[r_index_l][r_victim_l] <= r_tag_l;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // Count accepted hits and misses in IDLE
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if ((r_state == S_IDLE) && cpu_inst_req) begin
            if (w_hit) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign perf_hit_cnt  = rst ? r_hit_cnt  : 32'd0;
    assign perf_miss_cnt = rst ? r_miss_cnt : 32'd0;
`else
    assign perf_hit_cnt  = 32'd0;
    assign perf_miss_cnt = 32'd0;
`endif

    assign cpu_inst_addr_ok = w_idle_req;
    assign cpu_inst_data_ok = (w_idle_req && w_hit) || (rst && (r_state == S_RESP));
    assign cpu_inst_rdata   = !rst                  ? 32'd0 :
                              (r_state == S_RESP)   ? r_buf :
                              (w_idle_req && w_hit) ? w_hit_word : 32'd0;

    assign cache_inst_req   = rst && (r_state == S_REFILL) && !r_addr_sent;
    assign cache_inst_wr    = 1'b0;
    assign cache_inst_size  = rst ? 2'b10 : 2'b00;
    assign cache_inst_wdata = 32'd0;
    assign cache_inst_addr  = (rst && (r_state == S_REFILL)) ?
                              ({r_tag_l, r_index_l, OFFSET_WIDTH'(0)} | (32'(r_beat) << 2)) :
                              32'd0;

endmodule
